// File: rtl/cpu_core_exec_sequencer.sv
// Core execution sequencer: drives CRST/CEXEC from a reset/run/step/halt command handshake.
// Define CPU_CORE_SEQ_BREAKPOINT_EN to include the PC breakpoint compare.
module cpu_core_exec_sequencer #(
   parameter int unsigned RST_CYCLES = 16,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                 CCLK,
   input  logic                 CRSTN,
   input  logic                 CMD_VALID,
   output logic                 CMD_READY,
   input  logic [1:0]           CMD,
   input  logic [15:0]          STEP_NUM,
   input  logic [31:0]          BP_ADDR,
   input  logic                 BP_ENABLE,
   input  logic [31:0]          REGPC,
   output logic                 CRST,
   output logic                 CEXEC,
   output logic [1:0]           STATE,
   output logic [1:0]           HALT_CAUSE,
   output logic                 DONE,
   output logic [CNT_WIDTH-1:0] EXEC_CNT
);

   localparam int unsigned RstW = $clog2(RST_CYCLES + 1);

   localparam logic [RstW-1:0]      RstLoad = RstW'(RST_CYCLES);
   localparam logic [RstW-1:0]      RstOne  = RstW'(1);
   localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

   localparam logic [1:0] CmdReset = 2'b00;
   localparam logic [1:0] CmdRun   = 2'b01;
   localparam logic [1:0] CmdStep  = 2'b10;
   localparam logic [1:0] CmdHalt  = 2'b11;

   localparam logic [1:0] CauseNone = 2'b00;
   localparam logic [1:0] CauseCmd  = 2'b01;
   localparam logic [1:0] CauseStep = 2'b10;
   localparam logic [1:0] CauseBp   = 2'b11;

   typedef enum logic [1:0] {
      StReset = 2'd0,
      StHalt  = 2'd1,
      StRun   = 2'd2,
      StStep  = 2'd3
   } state_e;

   state_e          state_q;
   logic [RstW-1:0] rst_cnt_q;
   logic [15:0]     step_cnt_q;
   logic            first_q;

   logic cmd_acc;
   logic cmd_reset;
   logic cmd_run;
   logic cmd_step;
   logic cmd_halt;
   logic step_done;
   logic bp_hit;

   assign STATE = state_q;

   assign cmd_acc   = CMD_VALID & CMD_READY;
   assign cmd_reset = cmd_acc & (CMD == CmdReset);
   assign cmd_run   = cmd_acc & (CMD == CmdRun);
   assign cmd_step  = cmd_acc & (CMD == CmdStep);
   assign cmd_halt  = cmd_acc & (CMD == CmdHalt);

   assign step_done = (state_q == StStep) & CEXEC & (step_cnt_q == 16'd1);

`ifdef CPU_CORE_SEQ_BREAKPOINT_EN
   // First execute cycle after entry is masked so a resume from the breakpoint PC advances.
   assign bp_hit = CEXEC & BP_ENABLE & ~first_q & (REGPC == BP_ADDR);
`else
   logic unused_bp;
   assign unused_bp = ^{BP_ADDR, BP_ENABLE, REGPC, first_q};
   assign bp_hit    = 1'b0;
`endif

   always_ff @(posedge CCLK or negedge CRSTN) begin
      if (!CRSTN) begin
         state_q    <= StReset;
         rst_cnt_q  <= RstLoad;
         step_cnt_q <= '0;
         first_q    <= 1'b0;
         CRST       <= 1'b1;
         CEXEC      <= 1'b0;
         CMD_READY  <= 1'b0;
         HALT_CAUSE <= CauseNone;
         DONE       <= 1'b0;
         EXEC_CNT   <= '0;
      end else begin
         DONE <= 1'b0;
         if (CEXEC) begin
            EXEC_CNT <= EXEC_CNT + CntOne;
            first_q  <= 1'b0;
         end

         if (cmd_reset) begin
            // Only reachable from a ready state; overrides every other event.
            state_q    <= StReset;
            rst_cnt_q  <= RstLoad;
            CRST       <= 1'b1;
            CEXEC      <= 1'b0;
            CMD_READY  <= 1'b0;
            HALT_CAUSE <= CauseNone;
            EXEC_CNT   <= '0;
         end else begin
            unique case (state_q)
               StReset: begin
                  if (rst_cnt_q == RstOne) begin
                     state_q   <= StHalt;
                     CRST      <= 1'b0;
                     CMD_READY <= 1'b1;
                  end else begin
                     rst_cnt_q <= rst_cnt_q - RstOne;
                  end
               end

               StHalt: begin
                  if (cmd_run) begin
                     state_q <= StRun;
                     CEXEC   <= 1'b1;
                     first_q <= 1'b1;
                  end else if (cmd_step) begin
                     if (STEP_NUM == 16'd0) begin
                        HALT_CAUSE <= CauseStep;
                        DONE       <= 1'b1;
                     end else begin
                        state_q    <= StStep;
                        step_cnt_q <= STEP_NUM;
                        CEXEC      <= 1'b1;
                        first_q    <= 1'b1;
                     end
                  end
               end

               StRun, StStep: begin
                  if (cmd_halt) begin
                     state_q    <= StHalt;
                     CEXEC      <= 1'b0;
                     HALT_CAUSE <= CauseCmd;
                     DONE       <= 1'b1;
                  end else if (bp_hit) begin
                     state_q    <= StHalt;
                     CEXEC      <= 1'b0;
                     HALT_CAUSE <= CauseBp;
                     DONE       <= 1'b1;
                  end else if (step_done) begin
                     state_q    <= StHalt;
                     CEXEC      <= 1'b0;
                     HALT_CAUSE <= CauseStep;
                     DONE       <= 1'b1;
                  end else if ((state_q == StStep) && CEXEC) begin
                     step_cnt_q <= step_cnt_q - 16'd1;
                  end
               end

               default: begin
                  state_q <= StReset;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cpu_core_exec_sequencer.sv
// Scoreboard bench for cpu_core_exec_sequencer: expected halt records are queued by the
// stimulus and checked by a monitor on every DONE pulse; a 4-bit counter copy checks wrap.
`timescale 1ns/1ps
module tb_cpu_core_exec_sequencer;

   localparam logic [1:0] CmdReset = 2'b00;
   localparam logic [1:0] CmdRun   = 2'b01;
   localparam logic [1:0] CmdStep  = 2'b10;
   localparam logic [1:0] CmdHalt  = 2'b11;

   logic        CCLK      = 1'b0;
   logic        CRSTN     = 1'b1;
   logic        CMD_VALID = 1'b0;
   logic [1:0]  CMD       = 2'b00;
   logic [15:0] STEP_NUM  = 16'd0;
   logic [31:0] BP_ADDR   = 32'h100;
   logic        BP_ENABLE = 1'b1;
   logic [31:0] REGPC     = 32'h0F0;

   logic        CMD_READY, CRST, CEXEC, DONE;
   logic [1:0]  STATE, HALT_CAUSE;
   logic [31:0] EXEC_CNT;

   logic        ready_w4, crst_w4, cexec_w4, done_w4;
   logic [1:0]  state_w4, cause_w4;
   logic [3:0]  exec_cnt_w4;

   cpu_core_exec_sequencer #(.RST_CYCLES(16), .CNT_WIDTH(32)) dut (
      .CCLK(CCLK), .CRSTN(CRSTN), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD(CMD),
      .STEP_NUM(STEP_NUM), .BP_ADDR(BP_ADDR), .BP_ENABLE(BP_ENABLE), .REGPC(REGPC),
      .CRST(CRST), .CEXEC(CEXEC), .STATE(STATE), .HALT_CAUSE(HALT_CAUSE), .DONE(DONE),
      .EXEC_CNT(EXEC_CNT)
   );

   cpu_core_exec_sequencer #(.RST_CYCLES(16), .CNT_WIDTH(4)) dut_w4 (
      .CCLK(CCLK), .CRSTN(CRSTN), .CMD_VALID(CMD_VALID), .CMD_READY(ready_w4), .CMD(CMD),
      .STEP_NUM(STEP_NUM), .BP_ADDR(BP_ADDR), .BP_ENABLE(BP_ENABLE), .REGPC(REGPC),
      .CRST(crst_w4), .CEXEC(cexec_w4), .STATE(state_w4), .HALT_CAUSE(cause_w4),
      .DONE(done_w4), .EXEC_CNT(exec_cnt_w4)
   );

   always #5 CCLK = ~CCLK;

   typedef struct packed {
      logic [1:0]  cause;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   ec     = 0;

   function automatic exp_t mk(input logic [1:0] c, input logic [31:0] n);
      exp_t e;
      e.cause = c;
      e.cnt   = n;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic issue(input logic [1:0] c, input logic [15:0] n);
      @(negedge CCLK);
      check("cmd_ready", 32'(CMD_READY), 32'd1);
      CMD_VALID = 1'b1;
      CMD       = c;
      STEP_NUM  = n;
      @(negedge CCLK);
      CMD_VALID = 1'b0;
   endtask

   // Counts consecutive sampled cycles with CEXEC (sel_exec=1) or CRST high, bounded.
   task automatic count_high(input bit sel_exec, output int n);
      n = 0;
      while (((sel_exec ? CEXEC : CRST) == 1'b1) && n < 100) begin
         n++;
         @(negedge CCLK);
      end
   endtask

   always @(negedge CCLK) begin
      exp_t e;
      if (CRSTN && (DONE || done_w4)) begin
         check("done_w4_pair", 32'(done_w4), 32'(DONE));
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got DONE pulse, expected none at %0t", $time);
         end else begin
            e = sb.pop_front();
            check("done_state", 32'(STATE), 32'd1);
            check("done_cexec", 32'(CEXEC), 32'd0);
            check("done_cause", 32'(HALT_CAUSE), 32'(e.cause));
            check("done_exec_cnt", EXEC_CNT, e.cnt);
            check("done_exec_cnt_w4", 32'(exec_cnt_w4), 32'(e.cnt[3:0]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      #2 CRSTN = 1'b0;
      repeat (3) @(negedge CCLK);
      check("rst_state", 32'(STATE), 32'd0);
      check("rst_crst", 32'(CRST), 32'd1);
      check("rst_cexec", 32'(CEXEC), 32'd0);
      check("rst_ready", 32'(CMD_READY), 32'd0);
      check("rst_cause", 32'(HALT_CAUSE), 32'd0);
      check("rst_done", 32'(DONE), 32'd0);
      check("rst_exec_cnt", EXEC_CNT, 32'd0);

      CRSTN = 1'b1;
      count_high(1'b0, n);
      check("rst_hold_len", 32'(n), 32'd16);
      check("post_rst_state", 32'(STATE), 32'd1);
      check("post_rst_ready", 32'(CMD_READY), 32'd1);
      check("post_rst_exec_cnt", EXEC_CNT, 32'd0);

      // STEP 5
      ec = 5;
      sb.push_back(mk(2'b10, 32'(ec)));
      issue(CmdStep, 16'd5);
      count_high(1'b1, n);
      check("step5_len", 32'(n), 32'd5);
      check("step5_done", 32'(DONE), 32'd1);

      // STEP 0: no execution, immediate DONE
      sb.push_back(mk(2'b10, 32'(ec)));
      issue(CmdStep, 16'd0);
      check("step0_cexec", 32'(CEXEC), 32'd0);
      check("step0_cause", 32'(HALT_CAUSE), 32'd2);

      // HALT while halted is ignored (monitor flags any DONE)
      issue(CmdHalt, 16'd0);
      repeat (3) @(negedge CCLK);
      check("halt_in_halt_state", 32'(STATE), 32'd1);

      // Breakpoint at 0x100
      issue(CmdRun, 16'd0);
      check("run_cexec", 32'(CEXEC), 32'd1);
      repeat (3) @(negedge CCLK);
`ifdef CPU_CORE_SEQ_BREAKPOINT_EN
      ec = 9;
      sb.push_back(mk(2'b11, 32'(ec)));
      REGPC = 32'h100;
      @(negedge CCLK);
      check("bp_cexec", 32'(CEXEC), 32'd0);
      check("bp_cause", 32'(HALT_CAUSE), 32'd3);
      issue(CmdRun, 16'd0);
      check("bp_resume_c1", 32'(CEXEC), 32'd1);
      @(negedge CCLK);
      check("bp_resume_c2", 32'(CEXEC), 32'd1);
      REGPC = 32'h104;
      ec = 12;
`else
      REGPC = 32'h100;
      @(negedge CCLK);
      check("bp_ignored", 32'(CEXEC), 32'd1);
      ec = 11;
`endif
      sb.push_back(mk(2'b01, 32'(ec)));
      issue(CmdHalt, 16'd0);
      check("halt_cmd_cexec", 32'(CEXEC), 32'd0);
      check("halt_cmd_cause", 32'(HALT_CAUSE), 32'd1);
      REGPC = 32'h104;

      // HALT command coincides with step completion: command wins
      ec = ec + 3;
      sb.push_back(mk(2'b01, 32'(ec)));
      issue(CmdStep, 16'd3);
      @(negedge CCLK);
      issue(CmdHalt, 16'd0);
      check("step_halt_cexec", 32'(CEXEC), 32'd0);
      check("step_halt_cause", 32'(HALT_CAUSE), 32'd1);

      // RESET command during RUN
      issue(CmdRun, 16'd0);
      @(negedge CCLK);
      issue(CmdReset, 16'd0);
      check("rcmd_crst", 32'(CRST), 32'd1);
      check("rcmd_cexec", 32'(CEXEC), 32'd0);
      check("rcmd_state", 32'(STATE), 32'd0);
      check("rcmd_ready", 32'(CMD_READY), 32'd0);
      check("rcmd_cause", 32'(HALT_CAUSE), 32'd0);
      check("rcmd_exec_cnt", EXEC_CNT, 32'd0);
      check("rcmd_exec_cnt_w4", 32'(exec_cnt_w4), 32'd0);
      count_high(1'b0, n);
      check("rcmd_hold_len", 32'(n), 32'd16);
      check("rcmd_post_state", 32'(STATE), 32'd1);

      // RUN for 17 cycles: 4-bit counter wraps to 1
      ec = 17;
      sb.push_back(mk(2'b01, 32'(ec)));
      issue(CmdRun, 16'd0);
      repeat (15) @(negedge CCLK);
      issue(CmdHalt, 16'd0);

      repeat (5) @(negedge CCLK);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
